// File: rtl/ray_pixel_dispatcher.sv
// Raster-walking request initiator for the folded ray generator, with a show-ahead result FIFO.
// Latency: start -> first request 1 cycle; generator result -> ray_valid_out 1 cycle (registered push).
// Backpressure: a request is issued only if a FIFO slot is free. ray_ready_in=0 lets the FIFO fill, which then stops further requests.
//
// Ports: clk_in/rst_n_in (async active-low); start_in/cam_forward_in begin a frame.
//        gen_* : request (valid_out/hcount/vcount/cam_forward) and result (ready_in/valid_in/ray_in) to the generator.
//        ray_* : FIFO head to the march stage (valid/ready). busy_out, frame_done_out, protocol_err_out (sticky) report status.
// Optional feature: define RAY_DISPATCH_INTERLACE_EN for even-rows-then-odd-rows order.
module ray_pixel_dispatcher #(
   parameter int DISPLAY_WIDTH  = 4,
   parameter int DISPLAY_HEIGHT = 3,
   parameter int H_BITS         = 4,
   parameter int V_BITS         = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int VEC_BITS       = 48
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                start_in,
   input  logic [VEC_BITS-1:0] cam_forward_in,
   input  logic                gen_ready_in,
   input  logic                gen_valid_in,
   input  logic [VEC_BITS-1:0] gen_ray_in,
   output logic                gen_valid_out,
   output logic [H_BITS-1:0]   gen_hcount_out,
   output logic [V_BITS-1:0]   gen_vcount_out,
   output logic [VEC_BITS-1:0] gen_cam_forward_out,
   output logic                ray_valid_out,
   input  logic                ray_ready_in,
   output logic [H_BITS-1:0]   ray_hcount_out,
   output logic [V_BITS-1:0]   ray_vcount_out,
   output logic [VEC_BITS-1:0] ray_direction_out,
   output logic                busy_out,
   output logic                frame_done_out,
   output logic                protocol_err_out
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = H_BITS + V_BITS + VEC_BITS;
`ifdef RAY_DISPATCH_INTERLACE_EN
   // Odd rows come last, so the frame ends on the largest odd row (row 0 if there is only one row).
   localparam int LAST_ROW = (DISPLAY_HEIGHT == 1) ? 0 :
                             (((DISPLAY_HEIGHT - 1) % 2 == 1) ? DISPLAY_HEIGHT - 1 : DISPLAY_HEIGHT - 2);
`else
   localparam int LAST_ROW = DISPLAY_HEIGHT - 1;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [H_BITS-1:0]   hcount_q, hcount_d;
   logic [V_BITS-1:0]   vcount_q, vcount_d;
   logic [VEC_BITS-1:0] cam_q, cam_d;
   logic                frame_done_q, frame_done_d;
   logic                proto_err_q, proto_err_d;
   logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]  mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                issue, push, push_ok, pop, last_pix;
   logic [V_BITS-1:0]   next_row;

   // Credit rule: count_q < depth guarantees room for the single outstanding result.
   assign issue    = (state_q == ISSUE) && gen_ready_in && (count_q < CNT_W'(FIFO_DEPTH));
   assign push     = (state_q == WAIT) && gen_valid_in;
   assign push_ok  = push && (count_q != CNT_W'(FIFO_DEPTH));
   assign pop      = (count_q != '0) && ray_ready_in;
   assign last_pix = (int'(hcount_q) == DISPLAY_WIDTH - 1) && (int'(vcount_q) == LAST_ROW);

   always_comb begin
      next_row = vcount_q + 1'b1;
`ifdef RAY_DISPATCH_INTERLACE_EN
      // Step by two; after running off the bottom of the even rows, restart at row 1.
      if (int'(vcount_q) + 2 < DISPLAY_HEIGHT) begin
         next_row = vcount_q + V_BITS'(2);
      end else begin
         next_row = V_BITS'(1);
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      hcount_d     = hcount_q;
      vcount_d     = vcount_q;
      cam_d        = cam_q;
      frame_done_d = 1'b0;
      // A result arriving when nothing is outstanding is discarded and flagged until reset.
      proto_err_d  = proto_err_q | (gen_valid_in && (state_q != WAIT));

      case (state_q)
         IDLE: begin
            if (start_in) begin
               cam_d    = cam_forward_in;
               hcount_d = '0;
               vcount_d = '0;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (issue) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (gen_valid_in) begin
               if (int'(hcount_q) == DISPLAY_WIDTH - 1) begin
                  hcount_d = '0;
                  vcount_d = next_row;
               end else begin
                  hcount_d = hcount_q + 1'b1;
               end
               state_d = last_pix ? DRAIN : ISSUE;
            end
         end
         DRAIN: begin
            // No pushes happen here, so popping the only entry empties the FIFO.
            if (pop && (count_q == CNT_W'(1))) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {hcount_q, vcount_q, gen_ray_in};
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= IDLE;
         hcount_q     <= '0;
         vcount_q     <= '0;
         cam_q        <= '0;
         frame_done_q <= 1'b0;
         proto_err_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         cam_q        <= cam_d;
         frame_done_q <= frame_done_d;
         proto_err_q  <= proto_err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         mem_q        <= mem_d;
      end
   end

   assign gen_valid_out       = issue;
   assign gen_hcount_out      = hcount_q;
   assign gen_vcount_out      = vcount_q;
   assign gen_cam_forward_out = cam_q;
   assign ray_valid_out       = (count_q != '0);
   assign {ray_hcount_out, ray_vcount_out, ray_direction_out} = mem_q[rd_ptr_q];
   assign busy_out            = (state_q != IDLE);
   assign frame_done_out      = frame_done_q;
   assign protocol_err_out    = proto_err_q;

endmodule

// File: tb/tb_ray_pixel_dispatcher.sv
// Randomized bench for ray_pixel_dispatcher: generator model with variable latency, queue-based FIFO model.
// Latency: all expectations are evaluated #1 after the falling edge, once next-cycle inputs are applied.
// Backpressure: gen_ready_in and ray_ready_in are held, released, or randomized per test.
module tb_ray_pixel_dispatcher;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int D  = 2;
   localparam int HB = 4;
   localparam int VB = 4;
   localparam int VW = 48;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          start_in, gen_ready_in, gen_valid_in, ray_ready_in;
   logic [VW-1:0] cam_forward_in, gen_ray_in;
   logic          gen_valid_out, ray_valid_out, busy_out, frame_done_out, protocol_err_out;
   logic [HB-1:0] gen_hcount_out, ray_hcount_out;
   logic [VB-1:0] gen_vcount_out, ray_vcount_out;
   logic [VW-1:0] gen_cam_forward_out, ray_direction_out;

   ray_pixel_dispatcher #(
      .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB),
      .FIFO_DEPTH(D), .VEC_BITS(VW)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
      .cam_forward_in(cam_forward_in), .gen_ready_in(gen_ready_in),
      .gen_valid_in(gen_valid_in), .gen_ray_in(gen_ray_in),
      .gen_valid_out(gen_valid_out), .gen_hcount_out(gen_hcount_out),
      .gen_vcount_out(gen_vcount_out), .gen_cam_forward_out(gen_cam_forward_out),
      .ray_valid_out(ray_valid_out), .ray_ready_in(ray_ready_in),
      .ray_hcount_out(ray_hcount_out), .ray_vcount_out(ray_vcount_out),
      .ray_direction_out(ray_direction_out), .busy_out(busy_out),
      .frame_done_out(frame_done_out), .protocol_err_out(protocol_err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [HB-1:0] h;
      logic [VB-1:0] v;
      logic [VW-1:0] r;
   } ent_t;

   int checks = 0;
   int errors = 0;

   // Reference model state
   ent_t          mq[$];
   int            order_h[$];
   int            order_v[$];
   bit            outstanding, busy_m, err_m, exp_fd, last_pushed;
   int            cd, issued, pushed, popped, fd_cnt;
   logic [HB-1:0] oh;
   logic [VB-1:0] ov;
   logic [VW-1:0] cam_m, cam_drv, ray_drv;
   bit            gv_drv, start_drv, pop_pend, issue_pend;
   // Stimulus controls
   bit            start_req, inj_req, rand_start;
   int            gr_mode, rr_mode, lat_min, lat_max;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pixel order straight from the raster rules.
   task automatic build_order();
      int rows[$];
`ifdef RAY_DISPATCH_INTERLACE_EN
      for (int r = 0; r < H; r += 2) rows.push_back(r);
      for (int r = 1; r < H; r += 2) rows.push_back(r);
`else
      for (int r = 0; r < H; r++) rows.push_back(r);
`endif
      foreach (rows[i]) begin
         for (int x = 0; x < W; x++) begin
            order_h.push_back(x);
            order_v.push_back(rows[i]);
         end
      end
   endtask

   task automatic model_reset();
      mq.delete();
      outstanding = 0; busy_m = 0; err_m = 0; exp_fd = 0; last_pushed = 0;
      gv_drv = 0; start_drv = 0; pop_pend = 0; issue_pend = 0; cam_m = '0;
   endtask

   task automatic step();
      logic [63:0] rnd;
      bit gv, st;
      @(negedge clk_in);
      // Effects of the rising edge that just passed.
      if (start_drv && !busy_m) begin
         busy_m = 1; cam_m = cam_drv; issued = 0; pushed = 0; last_pushed = 0;
      end
      exp_fd = 0;
      if (pop_pend && mq.size() > 0) begin
         void'(mq.pop_front());
         popped++;
         if (last_pushed && mq.size() == 0) begin
            exp_fd = 1; busy_m = 0;
         end
      end
      if (gv_drv) begin
         if (outstanding) begin
            mq.push_back({oh, ov, ray_drv});
            outstanding = 0;
            pushed++;
            if (pushed == W * H) last_pushed = 1;
         end else begin
            err_m = 1;
         end
      end
      if (issue_pend) begin
         outstanding = 1;
         cd = $urandom_range(lat_min, lat_max) - 1;
      end else if (outstanding && cd > 0) begin
         cd--;
      end
      // Inputs for the next rising edge.
      st = start_req || (rand_start && busy_m && ($urandom_range(0, 15) == 0));
      start_req = 0;
      start_in = st; start_drv = st;
      rnd = {$urandom(), $urandom()};
      cam_forward_in = rnd[VW-1:0]; cam_drv = rnd[VW-1:0];
      gen_ready_in = (gr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(gr_mode);
      ray_ready_in = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'(rr_mode);
      gv = (outstanding && cd == 0) || inj_req;
      inj_req = 0;
      gen_valid_in = gv; gv_drv = gv;
      rnd = {$urandom(), $urandom()};
      gen_ray_in = rnd[VW-1:0]; ray_drv = rnd[VW-1:0];
      #1;
      chk("ray_valid", ray_valid_out, (mq.size() != 0) ? 1 : 0);
      if (ray_valid_out && mq.size() > 0) begin
         chk("head_h", ray_hcount_out, mq[0].h);
         chk("head_v", ray_vcount_out, mq[0].v);
         chk("head_ray", ray_direction_out, mq[0].r);
      end
      chk("frame_done", frame_done_out, exp_fd);
      fd_cnt += int'(frame_done_out);
      chk("busy", busy_out, busy_m);
      chk("proto_err", protocol_err_out, err_m);
      if (busy_m) chk("cam", gen_cam_forward_out, cam_m);
      if (outstanding) begin
         chk("hold_h", gen_hcount_out, oh);
         chk("hold_v", gen_vcount_out, ov);
      end
      issue_pend = 0;
      if (gen_valid_out) begin
         chk("issue_outstanding", outstanding, 0);
         chk("issue_credit", (mq.size() < D) ? 1 : 0, 1);
         if (issued < W * H) begin
            chk("issue_h", gen_hcount_out, 64'(order_h[issued]));
            chk("issue_v", gen_vcount_out, 64'(order_v[issued]));
            oh = HB'(order_h[issued]);
            ov = VB'(order_v[issued]);
         end else begin
            chk("extra_issue", 1, 0);
         end
         issued++;
         issue_pend = 1;
      end
      pop_pend = ray_valid_out && ray_ready_in;
   endtask

   task automatic run_frame(input int budget);
      int f0, n;
      f0 = fd_cnt; n = 0;
      while (fd_cnt == f0 && n < budget) begin
         step();
         n++;
      end
      chk("frame_timeout", (fd_cnt != f0) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      start_in = 0; gen_valid_in = 0; gen_ready_in = 0; ray_ready_in = 0;
      model_reset();
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   initial begin
      int p0, n;
      cam_forward_in = '0; gen_ray_in = '0;
      start_req = 0; inj_req = 0; rand_start = 0;
      gr_mode = 1; rr_mode = 1; lat_min = 7; lat_max = 7;
      fd_cnt = 0; popped = 0; issued = 0; pushed = 0; cd = 0;
      build_order();
      do_reset();
      #1;
      chk("rst_gen_valid", gen_valid_out, 0);
      chk("rst_ray_valid", ray_valid_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_frame_done", frame_done_out, 0);
      chk("rst_proto_err", protocol_err_out, 0);
      chk("rst_gen_h", gen_hcount_out, 0);
      chk("rst_ray_dir", ray_direction_out, 0);

      // Full frame, latency 7, no backpressure.
      p0 = popped; start_req = 1;
      step(); step();
      chk("start_to_issue", gen_valid_out, 1);
      run_frame(3000);
      chk("f1_issued", issued, W * H);
      chk("f1_popped", popped - p0, W * H);
      chk("f1_fd_count", fd_cnt, 1);
      step();
      chk("f1_idle", busy_out, 0);

      // Downstream stalled: credits cap issue at FIFO depth.
      rr_mode = 0; p0 = popped; start_req = 1;
      repeat (100) step();
      chk("stall_issued", issued, D);
      chk("stall_no_issue", gen_valid_out, 0);
      rr_mode = 1;
      run_frame(3000);
      chk("stall_popped", popped - p0, W * H);

      // Generator not ready after start.
      gr_mode = 0; start_req = 1;
      repeat (20) step();
      chk("gr_low_issued", issued, 0);
      gr_mode = 1;
      step();
      chk("gr_release_issue", gen_valid_out, 1);
      step();
      chk("gr_pulse_single", gen_valid_out, 0);
      run_frame(3000);

      // Randomized handshakes, latencies and ignored starts.
      gr_mode = 2; rr_mode = 2; lat_min = 1; lat_max = 9; rand_start = 1;
      for (int f = 0; f < 6; f++) begin
         p0 = popped; start_req = 1;
         step();
         run_frame(4000);
         chk("rand_popped", popped - p0, W * H);
      end
      rand_start = 0; gr_mode = 1; rr_mode = 1;
      repeat (3) step();

      // Spurious result while idle.
      inj_req = 1;
      repeat (5) step();
      chk("inj_err", protocol_err_out, 1);
      chk("inj_fifo_empty", ray_valid_out, 0);

      // Reset in WAIT with one entry buffered.
      rr_mode = 0; lat_min = 20; lat_max = 20; start_req = 1;
      n = 0;
      do begin
         step();
         n++;
      end while (!(outstanding && mq.size() == 1) && n < 300);
      chk("reach_wait_1", (outstanding && mq.size() == 1) ? 1 : 0, 1);
      #1 rst_n_in = 1'b0;
      #1;
      chk("mid_rst_gen_valid", gen_valid_out, 0);
      chk("mid_rst_ray_valid", ray_valid_out, 0);
      chk("mid_rst_busy", busy_out, 0);
      chk("mid_rst_err", protocol_err_out, 0);
      chk("mid_rst_gen_v", gen_vcount_out, 0);
      chk("mid_rst_ray_dir", ray_direction_out, 0);
      do_reset();
      // A late generator result after reset is a protocol error.
      inj_req = 1;
      step(); step();
      chk("late_result_err", protocol_err_out, 1);
      do_reset();
      rr_mode = 1; lat_min = 1; lat_max = 4; start_req = 1;
      step(); step();
      chk("restart_issue", gen_valid_out, 1);
      chk("restart_h", gen_hcount_out, 0);
      chk("restart_v", gen_vcount_out, 0);
      run_frame(3000);
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
